// File: rtl/rv_mem_responder_pkg.sv
// Shared bus encodings and byte-lane helpers for the RV32I memory responder.
// The lane-mask function is also used by the core's retire stage.
package rv_mem_responder_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   // Little-endian byte strobe for an access of the given size at addr[1:0].
   function automatic logic [3:0] f_lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << addr_lo;
         SIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Replicates LSB-justified write data across all lanes so any strobe picks the right bytes.
   function automatic logic [31:0] f_lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         SIZE_BYTE: lanes = {4{wdata[7:0]}};
         SIZE_HALF: lanes = {2{wdata[15:0]}};
         default:   lanes = wdata;
      endcase
      return lanes;
   endfunction

   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SIZE_HALF: mis = addr_lo[0];
         SIZE_WORD: mis = (addr_lo != 2'b00);
         default:   mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/rv_lat_pipe.sv
// Fixed-depth valid+data delay line with synchronous active-high clear.
// Clearing zeroes data as well so outputs read 0 while in reset.
module rv_lat_pipe #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vld,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_data
);

   logic              r_vld  [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_vld[i]  <= 1'b0;
            r_data[i] <= '0;
         end
      end else begin
         // stage 0 captures the request, later stages shift toward the output
         r_vld[0]  <= i_vld;
         r_data[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign o_vld  = r_vld[DEPTH-1];
   assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/rv_mem_responder.sv
// Shared-array memory responder: always-on instruction fetch, data read/write port, fixed RD_LAT.
// Define MISALIGN_TRAP_EN to drop misaligned half/word writes and flag misaligned accesses on o_err.
module rv_mem_responder
   import rv_mem_responder_pkg::*;
#(
   parameter int          DEPTH_LOG2 = 10,
   parameter int          RD_LAT     = 1,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_instr_addr,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   input  logic        i_read,
   input  logic [31:0] i_read_addr,
   output logic [31:0] o_rdata,
   output logic        o_rvalid,
   input  logic        i_write,
   input  logic [31:0] i_wr_addr,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   output logic        o_err
);

   localparam int          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;

   logic [31:0] r_mem [DEPTH];
   logic        r_err;

   logic [31:0]           w_i_off, w_r_off, w_w_off;
   logic                  w_i_inr, w_r_inr, w_w_inr;
   logic [DEPTH_LOG2-1:0] w_i_idx, w_r_idx, w_w_idx;
   logic [31:0]           w_i_word, w_r_word;
   logic                  w_rd_mis, w_wr_mis, w_wr_rsvd, w_wr_fault, w_wr_en;
   logic [3:0]            w_wr_mask;
   logic [31:0]           w_wr_lanes;
   logic                  w_err_next;

   // Offsets wrap at 32 bits, so addresses below BASE_ADDR land far out of range.
   assign w_i_off = i_instr_addr - BASE_ADDR;
   assign w_r_off = i_read_addr  - BASE_ADDR;
   assign w_w_off = i_wr_addr    - BASE_ADDR;

   assign w_i_inr = ({1'b0, w_i_off} < MEM_BYTES);
   assign w_r_inr = ({1'b0, w_r_off} < MEM_BYTES);
   assign w_w_inr = ({1'b0, w_w_off} < MEM_BYTES);

   assign w_i_idx = w_i_off[DEPTH_LOG2+1:2];
   assign w_r_idx = w_r_off[DEPTH_LOG2+1:2];
   assign w_w_idx = w_w_off[DEPTH_LOG2+1:2];

   // Reads sample the array before this edge's write lands: read-before-write.
   assign w_i_word = w_i_inr ? r_mem[w_i_idx] : 32'h0;
   assign w_r_word = (i_read && w_r_inr) ? r_mem[w_r_idx] : 32'h0;

`ifdef MISALIGN_TRAP_EN
   assign w_rd_mis = i_read && f_misaligned(i_size, i_read_addr[1:0]);
   assign w_wr_mis = f_misaligned(i_size, i_wr_addr[1:0]);
`else
   assign w_rd_mis = 1'b0;
   assign w_wr_mis = 1'b0;
`endif

   assign w_wr_rsvd  = (i_size == SIZE_RSVD);
   assign w_wr_fault = i_write && (!w_w_inr || w_wr_rsvd || w_wr_mis);
   assign w_wr_en    = i_write && !w_wr_fault;
   assign w_wr_mask  = f_lane_mask(i_size, i_wr_addr[1:0]);
   assign w_wr_lanes = f_lane_data(i_size, i_wdata);

   assign w_err_next = !w_i_inr || (i_read && !w_r_inr) || w_rd_mis || w_wr_fault;

   // Array has no reset; only writes presented during reset are suppressed.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (w_wr_mask[k]) r_mem[w_w_idx][8*k +: 8] <= w_wr_lanes[8*k +: 8];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_err <= 1'b0;
      else       r_err <= w_err_next;
   end

   assign o_err = r_err;

   rv_lat_pipe #(.DEPTH(RD_LAT), .DATA_W(32)) u_instr_pipe (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_vld  (1'b1),
      .i_data (w_i_word),
      .o_vld  (o_instr_valid),
      .o_data (o_instr)
   );

   rv_lat_pipe #(.DEPTH(RD_LAT), .DATA_W(32)) u_data_pipe (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_vld  (i_read),
      .i_data (w_r_word),
      .o_vld  (o_rvalid),
      .o_data (o_rdata)
   );

endmodule
